// File: rtl/wb_unit_pkg.sv
// Shared definitions for the writeback unit.
//   - Load size encodings as carried by ld_size and stored in the load queue.
//   - Register file bus widths and common constants.
package wb_unit_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic              True     = 1'b1;
  localparam logic              False    = 1'b0;

  // Encoding 2'b11 is reserved and handled exactly like a word load.
  typedef enum logic [1:0] {
    LdByte = 2'b00,
    LdHalf = 2'b01,
    LdWord = 2'b10
  } ldSize_e;

  // One outstanding load: where it goes and how to format its data.
  typedef struct packed {
    logic [RegAddrBus-1:0] waddr;
    logic [1:0]            size;
    logic                  uns;
    logic [1:0]            off;
  } ldEntry_t;

endpackage

// File: rtl/wb_ldq.sv
// In-order queue of outstanding load destinations.
// Each entry also produces a compare result against three query addresses.
// Two of these are the scoreboard queries, and one is the ALU WAW check.
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   i_push, i_push*    enqueue one load descriptor
//   i_pop              dequeue the head entry
//   o_head*            fields of the head entry
//   o_full, o_empty    occupancy flags
//   i_cmpAddrN         query addresses (N = 0..2)
//   o_hitN             per-entry match vector for query N (valid entries only)
module wb_ldq
  import wb_unit_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [RegAddrBus-1:0] i_pushAddr,
  input  logic [1:0]            i_pushSize,
  input  logic                  i_pushUns,
  input  logic [1:0]            i_pushOff,
  input  logic                  i_pop,
  output logic [RegAddrBus-1:0] o_headAddr,
  output logic [1:0]            o_headSize,
  output logic                  o_headUns,
  output logic [1:0]            o_headOff,
  output logic                  o_full,
  output logic                  o_empty,
  input  logic [RegAddrBus-1:0] i_cmpAddr0,
  input  logic [RegAddrBus-1:0] i_cmpAddr1,
  input  logic [RegAddrBus-1:0] i_cmpAddr2,
  output logic [DEPTH-1:0]      o_hit0,
  output logic [DEPTH-1:0]      o_hit1,
  output logic [DEPTH-1:0]      o_hit2
);

  ldEntry_t                r_mem [DEPTH];
  logic [DEPTH-1:0]        r_valid;
  logic [DEPTH_LOG2-1:0]   r_rdPtr;
  logic [DEPTH_LOG2-1:0]   r_wrPtr;
  logic [DEPTH_LOG2:0]     r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  // On a simultaneous push and pop while full, both pointers address the same slot.
  // The push is written after the pop clear, so the new entry stays valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (i_pop) begin
        r_valid[r_rdPtr] <= 1'b0;
        r_rdPtr          <= r_rdPtr + 1'b1;
      end
      if (i_push) begin
        r_mem[r_wrPtr]   <= '{waddr: i_pushAddr, size: i_pushSize,
                              uns: i_pushUns, off: i_pushOff};
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= r_wrPtr + 1'b1;
      end
      r_count <= r_count + {{DEPTH_LOG2{1'b0}}, i_push}
                         - {{DEPTH_LOG2{1'b0}}, i_pop};
    end
  end

  assign o_headAddr = r_mem[r_rdPtr].waddr;
  assign o_headSize = r_mem[r_rdPtr].size;
  assign o_headUns  = r_mem[r_rdPtr].uns;
  assign o_headOff  = r_mem[r_rdPtr].off;
  assign o_full     = (r_count == DEPTH[DEPTH_LOG2:0]);
  assign o_empty    = (r_count == '0);

  always_comb begin
    o_hit0 = '0;
    o_hit1 = '0;
    o_hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit0[i] = r_valid[i] && (r_mem[i].waddr == i_cmpAddr0);
      o_hit1[i] = r_valid[i] && (r_mem[i].waddr == i_cmpAddr1);
      o_hit2[i] = r_valid[i] && (r_mem[i].waddr == i_cmpAddr2);
    end
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit and the single writer of the register file write port.
// Load returns take priority over ALU/CSR results.
// The unit formats load data by byte or half lane with sign or zero extension.
// A scoreboard reports destinations of loads that are still in flight.
// Optional build macro: WB_STAT_EN adds the stat_wr and stat_stall counters.
// Ports:
//   clk, rst                           clock, synchronous active-low reset
//   alu_valid/ready/waddr/wdata        ALU/CSR result handshake
//   ld_valid/ready/waddr/size/uns/off  load issue, pushes the destination
//   mem_rvalid, mem_rdata              in-order load data return
//   q_addr1/2, q_pend1/2               pending-load scoreboard queries
//   we, waddr, wdata                   registered register file write port
//   err                                sticky flag: load data returned with none outstanding
//   stat_wr, stat_stall                (WB_STAT_EN only) write and stall counters
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [RegAddrBus-1:0] alu_waddr,
  input  logic [RegBus-1:0]     alu_wdata,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [RegAddrBus-1:0] ld_waddr,
  input  logic [1:0]            ld_size,
  input  logic                  ld_uns,
  input  logic [1:0]            ld_off,
  input  logic                  mem_rvalid,
  input  logic [RegBus-1:0]     mem_rdata,
  input  logic [RegAddrBus-1:0] q_addr1,
  input  logic [RegAddrBus-1:0] q_addr2,
  output logic                  q_pend1,
  output logic                  q_pend2,
  output logic                  we,
  output logic [RegAddrBus-1:0] waddr,
  output logic [RegBus-1:0]     wdata,
  output logic                  err
`ifdef WB_STAT_EN
  ,
  output logic [31:0]           stat_wr,
  output logic [31:0]           stat_stall
`endif
);

  logic                  w_push;
  logic                  w_pop;
  logic                  w_aluFire;
  logic                  w_full;
  logic                  w_empty;
  logic [RegAddrBus-1:0] w_headAddr;
  logic [1:0]            w_headSize;
  logic                  w_headUns;
  logic [1:0]            w_headOff;
  logic [DEPTH-1:0]      w_hitQ1;
  logic [DEPTH-1:0]      w_hitQ2;
  logic [DEPTH-1:0]      w_hitAlu;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [RegBus-1:0]     w_ldData;
  logic                  w_weNext;

  logic                  r_we;
  logic [RegAddrBus-1:0] r_waddr;
  logic [RegBus-1:0]     r_wdata;
  logic                  r_err;

  wb_ldq #(
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ldq (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushAddr (ld_waddr),
    .i_pushSize (ld_size),
    .i_pushUns  (ld_uns),
    .i_pushOff  (ld_off),
    .i_pop      (w_pop),
    .o_headAddr (w_headAddr),
    .o_headSize (w_headSize),
    .o_headUns  (w_headUns),
    .o_headOff  (w_headOff),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .i_cmpAddr0 (q_addr1),
    .i_cmpAddr1 (q_addr2),
    .i_cmpAddr2 (alu_waddr),
    .o_hit0     (w_hitQ1),
    .o_hit1     (w_hitQ2),
    .o_hit2     (w_hitAlu)
  );

  // A full queue still accepts a push when the head is leaving in the same cycle.
  // The ALU must wait on a load return (port priority).
  // It must also wait on any in-flight load to the same register, to keep WAW order.
  assign ld_ready  = !w_full || mem_rvalid;
  assign w_push    = ld_valid && ld_ready;
  assign w_pop     = mem_rvalid && !w_empty;
  assign alu_ready = rst && !mem_rvalid && !((alu_waddr != '0) && (|w_hitAlu));
  assign w_aluFire = alu_valid && alu_ready;

  // Queries see the queue as it was at the start of the cycle.
  // An entry popped this cycle still reports pending until its write lands.
  assign q_pend1 = (q_addr1 != '0) && (|w_hitQ1);
  assign q_pend2 = (q_addr2 != '0) && (|w_hitQ2);

  // Byte and half lanes are selected by the address low bits.
  // Reserved size 2'b11 is treated as a word.
  always_comb begin
    w_byte   = mem_rdata[{w_headOff, 3'b000} +: 8];
    w_half   = mem_rdata[{w_headOff[1], 4'b0000} +: 16];
    w_ldData = mem_rdata;
    case (w_headSize)
      LdByte:  w_ldData = w_headUns ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      LdHalf:  w_ldData = w_headUns ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ldData = mem_rdata;
    endcase
  end

  // An accepted write aimed at x0 still updates address and data, but never asserts we.
  assign w_weNext = w_pop     ? (w_headAddr != '0) :
                    w_aluFire ? (alu_waddr  != '0) : False;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we    <= False;
      r_waddr <= '0;
      r_wdata <= ZeroWord;
      r_err   <= False;
    end else begin
      r_we <= w_weNext;
      if (w_pop) begin
        r_waddr <= w_headAddr;
        r_wdata <= w_ldData;
      end else if (w_aluFire) begin
        r_waddr <= alu_waddr;
        r_wdata <= alu_wdata;
      end
      if (mem_rvalid && w_empty) begin
        r_err <= True;
      end
    end
  end

  assign we    = r_we;
  assign waddr = r_waddr;
  assign wdata = r_wdata;
  assign err   = r_err;

`ifdef WB_STAT_EN
  logic [31:0] r_statWr;
  logic [31:0] r_statStall;

  // Both counters wrap freely.
  // stat_wr counts the cycles that load we with 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_statWr    <= '0;
      r_statStall <= '0;
    end else begin
      if (w_weNext) begin
        r_statWr <= r_statWr + 32'd1;
      end
      if (alu_valid && !alu_ready) begin
        r_statStall <= r_statStall + 32'd1;
      end
    end
  end

  assign stat_wr    = r_statWr;
  assign stat_stall = r_statStall;
`endif

endmodule
